fifo_param: RTL and testbench

- Parametrised synchronous FIFO. Integrates in one block:
  - data storage;
  - read and write pointers;
  - occupancy counter;
  - operation state machine;
  - handshake and status outputs.
- Successor to the fixed 8-deep FIFO:
  - generalised in width, depth and almost-full/almost-empty thresholds;
  - adds a simultaneous read+write state.
- Sits between a producer and a consumer in a single clock domain.

---
 rtl/fifo_param.sv | 171 +++++++++++++++++
 tb/tb_fifo_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with registered read data, occupancy and status flags.
// Latency: one cycle from request to ack/err/d_out; flags decode registered data_count.
// Backpressure: no stall; writes when full and reads when empty are rejected with wr_err/rd_err.
module fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [2:0]            state
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);

    typedef enum logic [2:0] {
        ST_INIT     = 3'b000,
        ST_NO_OP    = 3'b001,
        ST_WRITE    = 3'b010,
        ST_READ     = 3'b011,
        ST_WR_ERROR = 3'b100,
        ST_RD_ERROR = 3'b101,
        ST_RW       = 3'b110,
        ST_UNUSED   = 3'b111
    } state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] d_out_q;
    logic                  wr_ack_q, wr_ack_d;
    logic                  wr_err_q, wr_err_d;
    logic                  rd_ack_q, rd_ack_d;
    logic                  rd_err_q, rd_err_d;
    logic                  do_wr, do_rd;
    logic                  full_w, empty_w;

    // Status flags are pure decodes of the registered count, so they never glitch on inputs.
    always_comb begin
        full_w       = (count_q == DEPTH_C);
        empty_w      = (count_q == '0);
        full         = full_w;
        empty        = empty_w;
        almost_full  = (count_q >= AF_C);
        almost_empty = (count_q <= AE_C);
    end

    // Decide this edge's operation from the requests and current occupancy only.
    always_comb begin
        state_d  = ST_NO_OP;
        do_wr    = 1'b0;
        do_rd    = 1'b0;
        wr_ack_d = 1'b0;
        wr_err_d = 1'b0;
        rd_ack_d = 1'b0;
        rd_err_d = 1'b0;
        case ({wr_en, rd_en})
            2'b10: begin
                if (full_w) begin
                    state_d  = ST_WR_ERROR;
                    wr_err_d = 1'b1;
                end else begin
                    state_d  = ST_WRITE;
                    do_wr    = 1'b1;
                    wr_ack_d = 1'b1;
                end
            end
            2'b01: begin
                if (empty_w) begin
                    state_d  = ST_RD_ERROR;
                    rd_err_d = 1'b1;
                end else begin
                    state_d  = ST_READ;
                    do_rd    = 1'b1;
                    rd_ack_d = 1'b1;
                end
            end
            2'b11: begin
                // Empty: nothing to read, so the write goes ahead alone.
                // Otherwise (even when full) the read frees the slot being written.
                do_wr    = 1'b1;
                wr_ack_d = 1'b1;
                if (empty_w) begin
                    state_d  = ST_WRITE;
                    rd_err_d = 1'b1;
                end else begin
                    state_d  = ST_RW;
                    do_rd    = 1'b1;
                    rd_ack_d = 1'b1;
                end
            end
            default: state_d = ST_NO_OP;
        endcase
    end

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control and output registers; reset clears everything except storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_INIT;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            d_out_q  <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
            rd_ack_q <= rd_ack_d;
            rd_err_q <= rd_err_d;
            // Reads sample the pre-edge array, so a same-slot write never bypasses.
            if (do_rd) begin
                d_out_q <= mem[rd_ptr_q];
            end
        end
    end

    // Storage array, not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_wr && reset_n) begin
            mem[wr_ptr_q] <= d_in;
        end
    end

    assign d_out      = d_out_q;
    assign data_count = count_q;
    assign wr_ack     = wr_ack_q;
    assign wr_err     = wr_err_q;
    assign rd_ack     = rd_ack_q;
    assign rd_err     = rd_err_q;
    assign state      = state_q;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param against a queue-based reference model.
// Latency: checks one cycle after each request edge, sampled #1 past posedge.
// Backpressure: exercises overflow/underflow rejection and simultaneous read+write.
module tb_fifo_param;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk;
    logic          reset_n;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] d_in;
    logic [DW-1:0] d_out;
    logic [AW:0]   data_count;
    logic          full, empty, almost_full, almost_empty;
    logic          wr_ack, wr_err, rd_ack, rd_err;
    logic [2:0]    state;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_dout;
    logic [2:0]    exp_state;
    logic          e_wack, e_werr, e_rack, e_rerr;

    fifo_param #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .d_in(d_in),
        .d_out(d_out),
        .data_count(data_count),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .wr_ack(wr_ack),
        .wr_err(wr_err),
        .rd_ack(rd_ack),
        .rd_err(rd_err),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string ctx);
        int n;
        n = mq.size();
        chk({ctx, ".state"},  64'(state),        64'(exp_state));
        chk({ctx, ".count"},  64'(data_count),   64'(n));
        chk({ctx, ".d_out"},  64'(d_out),        64'(exp_dout));
        chk({ctx, ".full"},   64'(full),         64'(n == DEPTH));
        chk({ctx, ".empty"},  64'(empty),        64'(n == 0));
        chk({ctx, ".afull"},  64'(almost_full),  64'(n >= AF));
        chk({ctx, ".aempty"}, 64'(almost_empty), 64'(n <= AE));
        chk({ctx, ".wr_ack"}, 64'(wr_ack),       64'(e_wack));
        chk({ctx, ".wr_err"}, 64'(wr_err),       64'(e_werr));
        chk({ctx, ".rd_ack"}, 64'(rd_ack),       64'(e_rack));
        chk({ctx, ".rd_err"}, 64'(rd_err),       64'(e_rerr));
    endtask

    task automatic model_reset();
        mq.delete();
        exp_dout  = '0;
        exp_state = 3'b000;
        e_wack = 1'b0; e_werr = 1'b0; e_rack = 1'b0; e_rerr = 1'b0;
    endtask

    // Behavioural model: the queue front is always the oldest stored word.
    task automatic model_edge(input logic w, input logic r, input logic [DW-1:0] din);
        int n;
        n = mq.size();
        e_wack = 1'b0; e_werr = 1'b0; e_rack = 1'b0; e_rerr = 1'b0;
        if (!w && !r) begin
            exp_state = 3'b001;
        end else if (w && !r) begin
            if (n == DEPTH) begin
                exp_state = 3'b100; e_werr = 1'b1;
            end else begin
                exp_state = 3'b010; e_wack = 1'b1; mq.push_back(din);
            end
        end else if (!w && r) begin
            if (n == 0) begin
                exp_state = 3'b101; e_rerr = 1'b1;
            end else begin
                exp_state = 3'b011; e_rack = 1'b1; exp_dout = mq.pop_front();
            end
        end else begin
            if (n == 0) begin
                exp_state = 3'b010; e_wack = 1'b1; e_rerr = 1'b1; mq.push_back(din);
            end else begin
                exp_state = 3'b110; e_wack = 1'b1; e_rack = 1'b1;
                exp_dout = mq.pop_front();
                mq.push_back(din);
            end
        end
    endtask

    task automatic step(input string ctx, input logic w, input logic r, input logic [DW-1:0] din);
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        d_in  = din;
        @(posedge clk);
        #1;
        model_edge(w, r, din);
        check_all(ctx);
    endtask

    initial begin
        logic [DW-1:0] v;
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        d_in    = '0;
        model_reset();

        // reset state before any clock edge
        #2;
        check_all("rst");

        @(negedge clk);
        reset_n = 1'b1;
        step("idle", 1'b0, 1'b0, '0);

        // fill to full, then overflow
        for (int i = 1; i <= 8; i++) begin
            v = 32'(i * 32'h11);
            step("fill", 1'b1, 1'b0, v);
        end
        step("ovf", 1'b1, 1'b0, 32'hDEAD_BEEF);
        chk("ovf.state_lit", 64'(state), 64'h4);

        // drain in order, then underflow
        for (int i = 1; i <= 8; i++) begin
            step("drain", 1'b0, 1'b1, '0);
            chk("drain.order", 64'(d_out), 64'(i * 32'h11));
        end
        step("udf", 1'b0, 1'b1, '0);
        chk("udf.hold", 64'(d_out), 64'h88);

        // simultaneous read+write at 0, 4 and 8
        step("rw0", 1'b1, 1'b1, 32'h5000_0000);
        chk("rw0.state_lit", 64'(state), 64'h2);
        for (int i = 1; i < 4; i++) step("rwfill4", 1'b1, 1'b0, 32'h5000_0000 + 32'(i));
        step("rw4", 1'b1, 1'b1, 32'h5000_0004);
        chk("rw4.oldest", 64'(d_out), 64'h5000_0000);
        for (int i = 0; i < 4; i++) step("rwfill8", 1'b1, 1'b0, 32'h6000_0000 + 32'(i));
        step("rw8", 1'b1, 1'b1, 32'h7000_0000);
        chk("rw8.full", 64'(full), 64'h1);
        for (int i = 0; i < 8; i++) step("rwdrain", 1'b0, 1'b1, '0);

        // wrap-around pass with pointers starting mid-array
        for (int i = 0; i < 5; i++) step("wrapw5", 1'b1, 1'b0, 32'hB0 + 32'(i));
        for (int i = 0; i < 5; i++) step("wrapr5", 1'b0, 1'b1, '0);
        for (int i = 1; i <= 6; i++) step("wrapw6", 1'b1, 1'b0, 32'hA0 + 32'(i));
        for (int i = 1; i <= 6; i++) begin
            step("wrapr6", 1'b0, 1'b1, '0);
            chk("wrap.order", 64'(d_out), 64'hA0 + 64'(i));
        end

        // randomized traffic, biased to swing between empty and full
        for (int i = 0; i < 1500; i++) begin
            int bias;
            bias = (i / 100) % 3;
            step("rand",
                 ($urandom_range(0, 99) < (bias == 0 ? 70 : (bias == 1 ? 30 : 50))),
                 ($urandom_range(0, 99) < (bias == 0 ? 30 : (bias == 1 ? 70 : 50))),
                 $urandom());
        end

        // asynchronous reset in the middle of a burst
        step("mid.idle", 1'b0, 1'b0, '0);
        while (mq.size() > 0) step("mid.drain", 1'b0, 1'b1, '0);
        for (int i = 0; i < 5; i++) step("mid.fill", 1'b1, 1'b0, 32'hC0 + 32'(i));
        step("mid.rd", 1'b0, 1'b1, '0);
        step("mid.wr", 1'b1, 1'b0, 32'hC5);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        @(negedge clk);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        reset_n = 1'b1;
        step("post.wr", 1'b1, 1'b0, 32'h1234_5678);
        step("post.rd", 1'b0, 1'b1, '0);
        chk("post.value", 64'(d_out), 64'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
